// File: rtl/cla_addsub_pipe_if.sv
// Operand/result bus for cla_addsub_pipe.
// Signal names follow the adder's point of view: *_i are driven into the adder, *_o out of it.
//   valid_i/ready_o   operand handshake (a_i, b_i, sub_i)
//   valid_o/ready_i   result handshake (sum_o, co_o, ovf_o, zero_o)
// Modports: slave = the adder, master = the operand source / result consumer.
interface cla_addsub_pipe_if #(
    parameter int unsigned WIDTH = 16
);
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             sub_i;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] sum_o;
    logic             co_o;
    logic             ovf_o;
    logic             zero_o;

    modport slave (
        input  valid_i, a_i, b_i, sub_i, ready_i,
        output ready_o, valid_o, sum_o, co_o, ovf_o, zero_o
    );

    modport master (
        output valid_i, a_i, b_i, sub_i, ready_i,
        input  ready_o, valid_o, sum_o, co_o, ovf_o, zero_o
    );
endinterface

// File: rtl/cla_addsub_pipe.sv
// Two-stage pipelined WIDTH-bit adder/subtractor with carry lookahead over 4-bit groups.
// Stage 1 registers per-bit propagate/generate, carry-in and per-group P/G.
// Stage 2 registers sum, carry out, signed overflow and zero flag.
// Ports:
//   clk_i   rising-edge clock
//   rst_i   synchronous active-high reset
//   bus_io  operand/result handshake bus (slave side), see cla_addsub_pipe_if
module cla_addsub_pipe #(
    parameter int unsigned WIDTH = 16
) (
    input logic              clk_i,
    input logic              rst_i,
    cla_addsub_pipe_if.slave bus_io
);

    localparam int NumGroups = WIDTH / 4;

    if ((WIDTH % 4) != 0 || WIDTH < 4 || WIDTH > 32) begin : gen_width_check
        $error("cla_addsub_pipe: WIDTH must be a multiple of 4 in 4..32");
    end

    // Stage 1 state
    logic                 s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]     p_q, p_d;
    logic [WIDTH-1:0]     g_q, g_d;
    logic                 cin_q, cin_d;
    logic [NumGroups-1:0] gp_q, gp_d;
    logic [NumGroups-1:0] gg_q, gg_d;

    // Stage 2 state
    logic                 valid_q, valid_d;
    logic [WIDTH-1:0]     sum_q, sum_d;
    logic                 co_q, co_d;
    logic                 ovf_q, ovf_d;
    logic                 zero_q, zero_d;

    // Combinational stage results
    logic [WIDTH-1:0]     b_x, p_x, g_x;
    logic [NumGroups-1:0] gp_x, gg_x;
    logic [NumGroups:0]   gc;     // carry into each group; gc[NumGroups] is the carry out
    logic [WIDTH:0]       c;      // carry into each bit; c[WIDTH] is the carry out
    logic [WIDTH-1:0]     sum_x;
    logic                 co_x, ovf_x, zero_x;

    logic                 s1_load, s2_load;

    // Handshake / advance
    assign s2_load        = !valid_q || bus_io.ready_i;
    assign s1_load        = !s1_valid_q || s2_load;
    assign bus_io.ready_o = s1_load;

    // Stage 1: subtraction as A + ~B + 1, then per-bit and per-group P/G
    always_comb begin
        b_x  = bus_io.b_i ^ {WIDTH{bus_io.sub_i}};
        p_x  = bus_io.a_i ^ b_x;
        g_x  = bus_io.a_i & b_x;
        gp_x = '0;
        gg_x = '0;
        for (int k = 0; k < NumGroups; k++) begin
            gp_x[k] = &p_x[4*k +: 4];
            gg_x[k] = g_x[4*k+3]
                    | (p_x[4*k+3] & g_x[4*k+2])
                    | (p_x[4*k+3] & p_x[4*k+2] & g_x[4*k+1])
                    | (p_x[4*k+3] & p_x[4*k+2] & p_x[4*k+1] & g_x[4*k]);
        end
    end

    // Stage 2: carries in flat sum-of-products lookahead form, first across groups,
    // then inside each group starting from that group's carry-in.
    always_comb begin
        logic term;
        logic cc;
        term = 1'b0;
        cc   = 1'b0;
        gc   = '0;
        c    = '0;

        for (int k = 0; k <= NumGroups; k++) begin
            term = cin_q;
            for (int m = 0; m < k; m++) begin
                term = term & gp_q[m];
            end
            cc = term;
            for (int j = 0; j < k; j++) begin
                term = gg_q[j];
                for (int m = j + 1; m < k; m++) begin
                    term = term & gp_q[m];
                end
                cc = cc | term;
            end
            gc[k] = cc;
        end

        for (int k = 0; k < NumGroups; k++) begin
            c[4*k] = gc[k];
            for (int i = 1; i < 4; i++) begin
                term = gc[k];
                for (int m = 0; m < i; m++) begin
                    term = term & p_q[4*k+m];
                end
                cc = term;
                for (int j = 0; j < i; j++) begin
                    term = g_q[4*k+j];
                    for (int m = j + 1; m < i; m++) begin
                        term = term & p_q[4*k+m];
                    end
                    cc = cc | term;
                end
                c[4*k+i] = cc;
            end
        end
        c[WIDTH] = gc[NumGroups];

        sum_x  = p_q ^ c[WIDTH-1:0];
        co_x   = c[WIDTH];
        ovf_x  = c[WIDTH] ^ c[WIDTH-1];
        zero_x = ~|sum_x;
    end

    // Next state: data registers only change when a real beat moves in, so outputs keep
    // their last value while valid_o is low.
    always_comb begin
        s1_valid_d = s1_valid_q;
        p_d        = p_q;
        g_d        = g_q;
        cin_d      = cin_q;
        gp_d       = gp_q;
        gg_d       = gg_q;
        valid_d    = valid_q;
        sum_d      = sum_q;
        co_d       = co_q;
        ovf_d      = ovf_q;
        zero_d     = zero_q;

        if (s1_load) begin
            s1_valid_d = bus_io.valid_i;
            if (bus_io.valid_i) begin
                p_d   = p_x;
                g_d   = g_x;
                cin_d = bus_io.sub_i;
                gp_d  = gp_x;
                gg_d  = gg_x;
            end
        end

        if (s2_load) begin
            valid_d = s1_valid_q;
            if (s1_valid_q) begin
                sum_d  = sum_x;
                co_d   = co_x;
                ovf_d  = ovf_x;
                zero_d = zero_x;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            p_q        <= '0;
            g_q        <= '0;
            cin_q      <= 1'b0;
            gp_q       <= '0;
            gg_q       <= '0;
            valid_q    <= 1'b0;
            sum_q      <= '0;
            co_q       <= 1'b0;
            ovf_q      <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            p_q        <= p_d;
            g_q        <= g_d;
            cin_q      <= cin_d;
            gp_q       <= gp_d;
            gg_q       <= gg_d;
            valid_q    <= valid_d;
            sum_q      <= sum_d;
            co_q       <= co_d;
            ovf_q      <= ovf_d;
            zero_q     <= zero_d;
        end
    end

    assign bus_io.valid_o = valid_q;
    assign bus_io.sum_o   = sum_q;
    assign bus_io.co_o    = co_q;
    assign bus_io.ovf_o   = ovf_q;
    assign bus_io.zero_o  = zero_q;

endmodule
